// File: rtl/conv_interleaver_ram.sv
// conv_interleaver_ram: convolutional (de)interleaver, NBR branches with per-branch delay steps of M symbols, sharing one read-first RAM
//   clk, reset_n (async, active-low), sync_clr: clock, reset, synchronous clear of pointers/primed/commutator
//   in_valid/in_ready/in_data: input stream; out_valid/out_ready/out_data: output stream
//   out_branch: branch the output passed through; out_primed: 0 when out_data is a zero fill symbol
module conv_interleaver_ram #(
  parameter int DW = 8,
  parameter int NBR = 12,
  parameter int M = 17,
  parameter int DEINT = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sync_clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data,
  output logic [$clog2(NBR)-1:0]  out_branch,
  output logic                    out_primed
);
  localparam int BW = $clog2(NBR);
  localparam int RS = M * NBR * (NBR - 1) / 2;
  localparam int AW = RS > 1 ? $clog2(RS) : 1;
  function automatic int blen(int b);
    return (DEINT != 0 ? NBR - 1 - b : b) * M;
  endfunction
  function automatic int bbase(int b);
    int s = 0;
    for (int k = 0; k < b; k++) s += blen(k);
    return s;
  endfunction
  // Per-branch constants; the last index is stored instead of the length so it always fits in AW bits.
  logic [AW-1:0] base_c [NBR];
  logic [AW-1:0] last_c [NBR];
  logic [NBR-1:0] byp_c;
  for (genvar g = 0; g < NBR; g++) begin : g_br
    assign base_c[g] = AW'(bbase(g));
    assign last_c[g] = blen(g) > 0 ? AW'(blen(g) - 1) : '0;
    assign byp_c[g] = blen(g) == 0;
  end
  logic [DW-1:0] mem [RS];
  logic [AW-1:0] ptr [NBR];
  logic [NBR-1:0] primed;
  logic [BW-1:0] br;
  logic acc, byp, wrap;
  logic [AW-1:0] addr;
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  assign byp = byp_c[br];
  assign addr = base_c[br] + ptr[br];
  assign wrap = ptr[br] == last_c[br];
  // Read-first: the output register samples the old word in the same edge that writes the new one.
  always_ff @(posedge clk)
    if (reset_n && acc && !sync_clr && !byp) mem[addr] <= in_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_branch <= '0;
      out_primed <= 1'b0;
      br <= '0;
      primed <= '0;
      for (int i = 0; i < NBR; i++) ptr[i] <= '0;
    end else if (sync_clr) begin
      out_valid <= 1'b0;
      br <= '0;
      primed <= '0;
      for (int i = 0; i < NBR; i++) ptr[i] <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_branch <= br;
      br <= br == BW'(NBR - 1) ? '0 : br + 1'b1;
      out_data <= byp ? in_data : primed[br] ? mem[addr] : '0;
      out_primed <= byp || primed[br];
      if (!byp) begin
        ptr[br] <= wrap ? '0 : ptr[br] + 1'b1;
        if (wrap) primed[br] <= 1'b1;
      end
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_conv_interleaver_ram.sv
// tb_conv_interleaver_ram: interleaver feeding deinterleaver, checked against an index-arithmetic delay model
module tb_conv_interleaver_ram;
  localparam int DW = 8;
  localparam int NBR = 12;
  localparam int M = 17;
  localparam int BW = $clog2(NBR);
  localparam int LOOP = (NBR - 1) * M * NBR;
  logic clk = 1'b0, reset_n = 1'b0, sync_clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic i_ready, i_valid, i_primed, d_ready, d_valid, d_primed;
  logic [DW-1:0] i_data, d_data;
  logic [BW-1:0] i_branch, d_branch;
  int tests = 0, fails = 0;
  int hist_i [$];
  int hist_d [$];
  int n_io = 0, n_do = 0;
  always #5 clk = ~clk;
  conv_interleaver_ram #(.DW(DW), .NBR(NBR), .M(M), .DEINT(0)) u_int (
    .clk(clk), .reset_n(reset_n), .sync_clr(sync_clr),
    .in_valid(in_valid), .in_ready(i_ready), .in_data(in_data),
    .out_valid(i_valid), .out_ready(d_ready), .out_data(i_data),
    .out_branch(i_branch), .out_primed(i_primed)
  );
  conv_interleaver_ram #(.DW(DW), .NBR(NBR), .M(M), .DEINT(1)) u_dei (
    .clk(clk), .reset_n(reset_n), .sync_clr(sync_clr),
    .in_valid(i_valid), .in_ready(d_ready), .in_data(i_data),
    .out_valid(d_valid), .out_ready(out_ready), .out_data(d_data),
    .out_branch(d_branch), .out_primed(d_primed)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Symbol n of a stage went through branch n%NBR on visit n/NBR; it is real data once that
  // visit index reaches the branch length, and then equals the stage input L*NBR slots earlier.
  function automatic void model(input int s, input int n, output int d, output int p);
    int b = n % NBR;
    int v = n / NBR;
    int l = (s != 0 ? NBR - 1 - b : b) * M;
    p = v >= l ? 1 : 0;
    d = p == 0 ? 0 : s != 0 ? hist_d[n - l * NBR] : hist_i[n - l * NBR];
  endfunction
  task automatic reset_model();
    hist_i.delete();
    hist_d.delete();
    n_io = 0;
    n_do = 0;
  endtask
  task automatic cycle(input bit v, input bit r, input bit c);
    int d, p;
    bit ip, dp, ir, dr;
    @(negedge clk);
    in_valid = v;
    in_data = DW'($urandom);
    out_ready = r;
    sync_clr = c;
    #1;
    ip = hist_i.size() != n_io;
    dp = hist_d.size() != n_do;
    dr = !dp || r;
    ir = !ip || dr;
    check("i_valid", 32'(i_valid), 32'(ip));
    check("d_valid", 32'(d_valid), 32'(dp));
    check("i_ready", 32'(i_ready), 32'(ir));
    check("d_ready", 32'(d_ready), 32'(dr));
    if (i_valid && ip) begin
      model(0, n_io, d, p);
      check("i_data", 32'(i_data), d);
      check("i_primed", 32'(i_primed), p);
      check("i_branch", 32'(i_branch), n_io % NBR);
    end
    if (d_valid && dp) begin
      model(1, n_do, d, p);
      check("d_data", 32'(d_data), d);
      check("d_primed", 32'(d_primed), p);
      check("d_branch", 32'(d_branch), n_do % NBR);
      if (n_do >= LOOP) begin
        check("loop_data", 32'(d_data), hist_i[n_do - LOOP]);
        check("loop_primed", 32'(d_primed), 1);
      end
    end
    if (c) reset_model();
    else begin
      if (ip && dr) begin
        model(0, n_io, d, p);
        hist_d.push_back(d);
        n_io++;
      end
      if (dp && r) n_do++;
      if (v && ir) hist_i.push_back(int'(in_data));
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_i_valid"}, 32'(i_valid), 0);
    check({tag, "_d_valid"}, 32'(d_valid), 0);
    check({tag, "_i_branch"}, 32'(i_branch), 0);
    check({tag, "_d_branch"}, 32'(d_branch), 0);
  endtask
  initial begin
    int guard;
    repeat (2) @(negedge clk);
    check_idle("rst");
    check("rst_i_data", 32'(i_data), 0);
    check("rst_i_primed", 32'(i_primed), 0);
    check("rst_d_primed", 32'(d_primed), 0);
    check("rst_i_ready", 32'(i_ready), 1);
    reset_n = 1'b1;
    repeat (3000) cycle(1'b1, 1'b1, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    repeat (2500) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0);
    repeat (20) cycle(1'b1, 1'b1, 1'b0);
    guard = 0;
    while (hist_i.size() % NBR != 7 && guard < 40) begin
      cycle(1'b1, 1'b1, 1'b0);
      guard++;
    end
    check("br7_reached", 32'(hist_i.size() % NBR), 7);
    cycle(1'b1, 1'b1, 1'b1);
    repeat (400) cycle(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    check("pre_arst_valid", 32'(i_valid), 1);
    reset_n = 1'b0;
    #1;
    check_idle("arst");
    reset_model();
    in_valid = 1'b0;
    sync_clr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (300) cycle(1'b1, $urandom_range(0, 4) != 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
